// File: rtl/spi_pkg.sv
// Shared SPI receive-path constants and the stored FIFO entry layout.
package spi_pkg;

  localparam int SPI_BYTE_W        = 8;
  localparam int SPI_RX_FIFO_DEPTH = 8;

  typedef struct packed {
    logic                  first;
    logic [SPI_BYTE_W-1:0] data;
  } spi_rx_entry_t;

endpackage

// File: rtl/spi_rx_fifo_mem.sv
// Register array for the SPI receive FIFO: one synchronous write port and one
// asynchronous read port so the head entry falls through combinationally.
module spi_rx_fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [DATA_W:0]            wr_entry,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr,
  output logic [DATA_W:0]            rd_entry
);

  logic [DATA_W:0] mem [DEPTH];

  // Contents are never reset; validity is tracked by the pointer logic.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_entry;
  end

  assign rd_entry = mem[rd_addr];

endmodule

// File: rtl/spi_rx_byte_fifo.sv
// Byte FIFO behind the MISO deserializer with frame-start tagging, fill level
// and sticky overflow. Define SPI_RX_OVF_CNT_EN to add the ovf_count output.
module spi_rx_byte_fifo
  import spi_pkg::*;
#(
  parameter int DATA_W = SPI_BYTE_W,
  parameter int DEPTH  = SPI_RX_FIFO_DEPTH
) (
  input  logic                     spi_clk,
  input  logic                     spi_rst,
  input  logic                     spi_cs,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     wr_valid,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_first,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     overflow,
`ifdef SPI_RX_OVF_CNT_EN
  output logic [7:0]               ovf_count,
`endif
  input  logic                     ovf_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            first_pending;
  logic            push;
  logic            pop;
  logic            drop;
  logic [DATA_W:0] wr_entry;
  logic [DATA_W:0] head_entry;

  assign full     = (level == LW'(DEPTH));
  assign rd_valid = (level != '0);

  // A flush swallows everything in its cycle, including would-be drops.
  assign pop  = rd_valid & rd_ready & ~flush;
  assign push = wr_valid & (~full | pop) & ~flush;
  assign drop = wr_valid & full & ~pop & ~flush;

  // Chip-select high in the push cycle already marks a new frame.
  assign wr_entry = {first_pending | spi_cs, wr_data};

  spi_rx_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk      (spi_clk),
    .wr_en    (push),
    .wr_addr  (wr_ptr),
    .wr_entry (wr_entry),
    .rd_addr  (rd_ptr),
    .rd_entry (head_entry)
  );

  assign rd_data  = rd_valid ? head_entry[DATA_W-1:0] : '0;
  assign rd_first = rd_valid & head_entry[DATA_W];

  always_ff @(posedge spi_clk or posedge spi_rst) begin
    if (spi_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge spi_clk or posedge spi_rst) begin
    if (spi_rst) begin
      first_pending <= 1'b1;
      overflow      <= 1'b0;
    end else begin
      if (spi_cs)    first_pending <= 1'b1;
      else if (push) first_pending <= 1'b0;
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

`ifdef SPI_RX_OVF_CNT_EN
  always_ff @(posedge spi_clk or posedge spi_rst) begin
    if (spi_rst)                 ovf_count <= 8'd0;
    else if (ovf_clr)            ovf_count <= drop ? 8'd1 : 8'd0;
    else if (drop && ovf_count != 8'hFF) ovf_count <= ovf_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_spi_rx_byte_fifo.sv
// Scoreboard bench for spi_rx_byte_fifo; optional ovf_count checks under SPI_RX_OVF_CNT_EN.
module tb_spi_rx_byte_fifo;

  logic       spi_clk = 1'b0;
  logic       spi_rst;
  logic       spi_cs;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic [7:0] rd_data;
  logic       rd_first;
  logic       rd_valid;
  logic       rd_ready;
  logic       flush;
  logic [3:0] level;
  logic       full;
  logic       overflow;
  logic       ovf_clr;
`ifdef SPI_RX_OVF_CNT_EN
  logic [7:0] ovf_count;
`endif

  int checks   = 0;
  int failures = 0;
  logic [8:0] expq [$];

  spi_rx_byte_fifo #(.DATA_W(8), .DEPTH(8)) dut (
    .spi_clk  (spi_clk),
    .spi_rst  (spi_rst),
    .spi_cs   (spi_cs),
    .wr_data  (wr_data),
    .wr_valid (wr_valid),
    .rd_data  (rd_data),
    .rd_first (rd_first),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .flush    (flush),
    .level    (level),
    .full     (full),
    .overflow (overflow),
`ifdef SPI_RX_OVF_CNT_EN
    .ovf_count(ovf_count),
`endif
    .ovf_clr  (ovf_clr)
  );

  always #5 spi_clk = ~spi_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every handshake on the read port consumes one scoreboard entry.
  always @(negedge spi_clk) begin
    if (!spi_rst && rd_valid && rd_ready) begin
      checks++;
      if (expq.size() == 0) begin
        failures++;
        $display("[TB] FAIL pop_unexpected: got 0x%0h first=%0b expected nothing", rd_data, rd_first);
      end else begin
        logic [8:0] e;
        e = expq.pop_front();
        if ({rd_first, rd_data} !== e) begin
          failures++;
          $display("[TB] FAIL pop_data: got first=%0b data=0x%0h expected first=%0b data=0x%0h",
                   rd_first, rd_data, e[8], e[7:0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge spi_clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic expect_first, input bit queued);
    wr_valid = 1'b1;
    wr_data  = d;
    if (queued) expq.push_back({expect_first, d});
    step();
    wr_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (rd_valid && n < 50) begin
      step();
      n++;
    end
    check({name, "_drained"}, {31'd0, rd_valid}, 32'd0);
  endtask

  initial begin
    spi_rst = 1'b1; spi_cs = 1'b1; wr_data = '0; wr_valid = 1'b0;
    rd_ready = 1'b0; flush = 1'b0; ovf_clr = 1'b0;
    step(); step();
    check("rst_level", level, 0);
    check("rst_valid", rd_valid, 0);
    check("rst_full", full, 0);
    check("rst_ovf", overflow, 0);
    check("rst_data", {rd_first, rd_data}, 0);
    spi_rst = 1'b0;
    step();

    // Basic flow
    spi_cs = 1'b0;
    applyStimulus(8'h80, 1'b1, 1);
    applyStimulus(8'h40, 1'b0, 1);
    applyStimulus(8'hC0, 1'b0, 1);
    check("basic_level", level, 3);
    rd_ready = 1'b1;
    wait_drain("basic");
    check("basic_level0", level, 0);

    // Frame tagging across chip-select pulses
    spi_cs = 1'b1; step(); spi_cs = 1'b0;
    applyStimulus(8'h11, 1'b1, 1);
    step();
    spi_cs = 1'b1; step(); spi_cs = 1'b0;
    applyStimulus(8'h22, 1'b1, 1);
    applyStimulus(8'h33, 1'b0, 1);
    wait_drain("tag");

    // Fill, drop, clear
    rd_ready = 1'b0;
    for (int i = 1; i <= 8; i++) applyStimulus(8'(i), 1'b0, 1);
    check("fill_full", full, 1);
    check("fill_level", level, 8);
    applyStimulus(8'hFF, 1'b0, 0);
    check("drop_ovf", overflow, 1);
    check("drop_level", level, 8);
    ovf_clr = 1'b1;
    applyStimulus(8'hFE, 1'b0, 0);
    ovf_clr = 1'b0;
    check("clr_drop_ovf", overflow, 1);
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    check("clr_ovf", overflow, 0);

    // Full with simultaneous push and pop
    rd_ready = 1'b1;
    applyStimulus(8'h09, 1'b0, 1);
    rd_ready = 1'b0;
    check("fullpp_level", level, 8);
    check("fullpp_ovf", overflow, 0);
    rd_ready = 1'b1;
    wait_drain("fullpp");

    // Pointer wrap with streaming push/pop
    for (int i = 0; i < 20; i++) applyStimulus(8'h20 + 8'(i), 1'b0, 1);
    wait_drain("wrap");

    // Flush while full with overflow set keeps overflow
    rd_ready = 1'b0;
    for (int i = 0; i < 8; i++) applyStimulus(8'h60 + 8'(i), 1'b0, 0);
    applyStimulus(8'hEE, 1'b0, 0);
    flush = 1'b1;
    applyStimulus(8'h77, 1'b0, 0);
    flush = 1'b0;
    check("flushf_level", level, 0);
    check("flushf_valid", rd_valid, 0);
    check("flushf_ovf", overflow, 1);
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;

    // Flush with 5 entries and a concurrent push
    for (int i = 0; i < 5; i++) applyStimulus(8'h50 + 8'(i), 1'b0, 0);
    check("flush5_pre", level, 5);
    flush = 1'b1;
    applyStimulus(8'h99, 1'b0, 0);
    flush = 1'b0;
    check("flush5_level", level, 0);
    check("flush5_valid", rd_valid, 0);
    check("flush5_ovf", overflow, 0);
    applyStimulus(8'hAB, 1'b0, 1);
    rd_ready = 1'b1;
    wait_drain("postflush");

`ifdef SPI_RX_OVF_CNT_EN
    rd_ready = 1'b0;
    for (int i = 0; i < 8; i++) applyStimulus(8'h70 + 8'(i), 1'b0, 0);
    for (int i = 0; i < 300; i++) applyStimulus(8'hDD, 1'b0, 0);
    check("cnt_sat", ovf_count, 255);
    ovf_clr = 1'b1;
    applyStimulus(8'hDD, 1'b0, 0);
    ovf_clr = 1'b0;
    check("cnt_clr_drop", ovf_count, 1);
    flush = 1'b1; step(); flush = 1'b0;
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
`endif

    // Async reset mid-frame
    rd_ready = 1'b0;
    applyStimulus(8'h31, 1'b0, 0);
    applyStimulus(8'h32, 1'b0, 0);
    #2 spi_rst = 1'b1;
    #1;
    check("arst_level", level, 0);
    check("arst_valid", rd_valid, 0);
    step();
    spi_rst = 1'b0;

    check("scoreboard_empty", expq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_rx_byte_fifo.md
Name: spi_rx_byte_fifo

Overview:
Buffers bytes received by the MISO deserializer (spi_miso) until the host-side logic reads them. Sits directly downstream of spi_miso: accepts one parallel byte per strobe, tags the first byte of each chip-select frame, and presents bytes in order on a valid/ready read port. Also reports fill level and overflow.

Parameters:
DATA_W, 8, width of one received word (matches spi_miso_out).
DEPTH, 8, number of entries; power of 2, minimum 2.

Ports:
spi_clk  input  1  block clock; all state updates on rising edge.
spi_rst  input  1  asynchronous active-high reset.
spi_cs  input  1  chip select, active low, sampled on spi_clk; high marks end of frame.
wr_data  input  DATA_W  byte from spi_miso.
wr_valid  input  1  one-cycle strobe: wr_data holds a completed byte.
rd_data  output  DATA_W  head-of-queue byte (first-word fall-through).
rd_first  output  1  head byte is the first byte of its frame.
rd_valid  output  1  queue not empty.
rd_ready  input  1  consumer accepts head when rd_valid is 1.
flush  input  1  synchronous clear of queue contents.
level  output  $clog2(DEPTH)+1  number of stored entries.
full  output  1  level == DEPTH.
overflow  output  1  sticky: a byte was dropped.
ovf_clr  input  1  clears overflow.

Behaviour:
- Reset (async, spi_rst=1): pointers=0, level=0, rd_valid=0, rd_data=0, rd_first=0, full=0, overflow=0, first_pending=1. Memory contents are don't-care.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Push: accepted when wr_valid=1 and (full=0, or a pop occurs in the same cycle). The stored entry is {first_pending, wr_data}.
- Pop: occurs when rd_valid=1 and rd_ready=1. The read pointer advances.
- Read port latency: a byte written at edge N appears at rd_data/rd_valid after edge N. There is no same-cycle bypass when empty; rd_ready while empty is ignored.
- rd_data and rd_first are driven from the head entry; their values while rd_valid=0 are don't-care.
- Simultaneous push and pop: both take effect and level is unchanged. This includes the full case.
- Overflow: wr_valid=1 while full=1 with no pop. The byte is dropped, overflow is set, and first_pending is unchanged, so the next accepted byte keeps the tag.
- overflow clears on ovf_clr=1. If ovf_clr and a new drop occur in the same cycle, overflow stays 1.
- Frame tagging: first_pending is set while spi_cs=1 and cleared by any accepted push while spi_cs=0. If spi_cs=1 and a push happen in the same cycle, the entry is tagged 1 and first_pending stays 1.
- flush=1: pointers and level go to 0 and rd_valid goes to 0 next cycle. Any wr_valid in the same cycle is discarded without setting overflow. flush does not alter overflow or first_pending.
- spi_rst asserted mid-frame or mid-read: immediate return to reset values. The consumer must not rely on data after reset.

Optional Feature:
SPI_RX_OVF_CNT_EN: when defined, adds output ovf_count [7:0]. It increments on each dropped byte, saturates at 255, resets to 0 on spi_rst, and clears on ovf_clr. If a drop and ovf_clr occur in the same cycle, the result is 1. When not defined, the port and counter are absent and only the sticky overflow flag exists.

Decomposition:
- Shared package spi_pkg holds: SPI_BYTE_W=8, SPI_RX_FIFO_DEPTH=8, and typedef spi_rx_entry_t {logic first; logic [SPI_BYTE_W-1:0] data}.
- One sub-module, spi_rx_fifo_mem: a DEPTH x (DATA_W+1) register array with one synchronous write port and one asynchronous read port.
- Pointer, level and flag logic stays in spi_rx_byte_fifo.

Test Plan:
- Reset then basic flow: assert spi_rst, then spi_cs=0; push 0x80, 0x40, 0xC0 with rd_ready=0 -> level=3. Raise rd_ready -> bytes pop in order 0x80, 0x40, 0xC0 with rd_first=1,0,0; then rd_valid=0 and level=0.
- Frame tagging: push 0x11, raise spi_cs for 1 cycle, lower it, push 0x22 -> rd_first=1 for both.
- Fill to DEPTH with 0x01..0x08 -> full=1. Push 0xFF -> dropped, overflow=1, and the contents read back 0x01..0x08. Pulse ovf_clr -> overflow=0.
- Full with simultaneous push 0x09 and pop -> level stays 8; read order is 0x02..0x09 and overflow stays 0.
- Pointer wrap: 20 push/pop pairs of incrementing values -> every value matches in order across pointer wrap.
- Flush with 5 entries and a concurrent push -> level=0 and rd_valid=0 next cycle, overflow unchanged. With SPI_RX_OVF_CNT_EN: 300 drops -> ovf_count=255.
